lpif_ll_credit_fifo: RTL
========================

Name: lpif_ll_credit_fifo

Overview:
Parametrised logic-link buffer that replaces the FIFO/credit bypass in the LPIF txrx top levels.
- RX direction: buffers words from the PHY concat block in a DEPTH-entry FIFO, hands them to the user interface with valid/ready, and returns one credit per word consumed.
- TX direction: keeps an upstream credit counter that gates user pushes toward the concat block.
- Sits between the *_name user-interface block and the *_concat PHY block, driven by the auto-sync online signals.

Parameters:
- DATA_W, 537, logic-link word width (both directions).
- DEPTH, 16, RX FIFO entries; power of 2, 2..128.
- CREDIT_W, 8, TX credit counter width; 1..8.

Ports:
- clk_wr  in  1  single clock for the whole block.
- rst_wr  in  1  synchronous reset, active-high.
- rx_online  in  1  RX online, from auto-sync rx_online_delay.
- tx_online  in  1  TX online, from auto-sync tx_online_delay.
- init_upstream_credit  in  8  credit value loaded on tx_online rise; low CREDIT_W bits used.
- rx_push  in  1  valid word present on rx_data this cycle.
- rx_data  in  DATA_W  received word from concat.
- rx_fifo_valid  out  1  FIFO head valid to user.
- rx_fifo_data  out  DATA_W  FIFO head word.
- rx_fifo_ready  in  1  user accepts head.
- rx_credit_ret  out  1  one-cycle pulse, one credit returned to far end.
- tx_valid  in  1  user upstream word valid.
- tx_data  in  DATA_W  user upstream word.
- tx_ready  out  1  upstream word accepted this cycle.
- tx_credit_in  in  1  pulse, one credit received from far end.
- tx_push  out  1  registered word valid to concat.
- tx_push_data  out  DATA_W  registered word to concat.
- rx_debug_status  out  32  RX status word.
- tx_debug_status  out  32  TX status word.

Behaviour:
Reset (rst_wr=1 at a clock edge) clears all state:
- Pointers, count, credit counter and stickies all 0.
- Outputs rx_fifo_valid, rx_credit_ret, tx_ready, tx_push = 0; tx_push_data = 0.
- rx_fifo_data is don't-care while rx_fifo_valid = 0.

RX FIFO:
- Write when rx_push & rx_online & !full. Write while full: word dropped, rx_ovf_sticky set.
- rx_fifo_valid = !empty; rx_fifo_data = mem[rd_ptr] (first-word fall-through).
- Pop when rx_fifo_valid & rx_fifo_ready.
- Latency: a word written at edge N is visible after edge N.
- Write and pop in the same cycle: count unchanged; legal when full (pop frees the slot in that cycle). When empty, only the write occurs.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits; full = (count == DEPTH).
- rx_credit_ret is registered: it pulses on the cycle after each pop.
- rx_online low: pointers and count cleared next edge, pending credit return suppressed, incoming pushes ignored.
- Reaching full when rx_online falls: flush wins.

TX credit:
- Edge detect on tx_online: on the rising edge, cnt <= init_upstream_credit[CREDIT_W-1:0].
- tx_ready = tx_online & (cnt != 0), combinational; it is held low in the tx_online rise cycle.
- Consume = tx_valid & tx_ready.
- Counter update rules:
  - tx_credit_in only: cnt+1.
  - Consume only: cnt-1.
  - Both in the same cycle: cnt unchanged.
  - tx_credit_in at cnt = all-ones with no consume: cnt saturates and tx_cred_ovf_sticky is set.
  - tx_credit_in while tx_online is low: ignored.
- tx_online low: cnt <= 0 next edge.
- tx_push <= consume; tx_push_data <= tx_data when consume, otherwise holds its value. Latency 1.

Debug status (both words share layout):
- [31] rx_ovf_sticky
- [30] tx_cred_ovf_sticky
- [29] rx_online
- [28] tx_online
- [27:16] zero
- [15:8] RX count, zero-extended
- [7:0] credit cnt, zero-extended
- Stickies clear only on reset.

Decomposition:
- Package lpif_ll_pkg holds:
  - debug-status bit-position constants
  - clog2-based width function
  - max DEPTH/CREDIT_W constants with elaboration-time checks
- One sub-module, lpif_ll_sync_fifo: DATA_W x DEPTH first-word-fall-through memory with pointers, count, full/empty and a flush input.
- Credit logic stays in the top.

Test Plan:
1. Reset, rx_online=1, push 3 words A,B,C with rx_fifo_ready=0 -> rx_fifo_valid=1, data=A, debug[15:8]=3. Then ready=1 for 3 cycles -> A,B,C in order, three rx_credit_ret pulses each one cycle after its pop.
2. DEPTH=16: push 17 words with no pops -> count=16 and debug[31]=1; the 17th word is never output. Next, push and pop in the same cycle while full -> count stays 16 and the word is stored.
3. rx_online drops with 5 words buffered -> rx_fifo_valid=0 next cycle, no rx_credit_ret pulses.
4. init_upstream_credit=2, raise tx_online, hold tx_valid=1 -> exactly 2 tx_ready cycles, tx_push follows one cycle later with matching data, then tx_ready=0. One tx_credit_in pulse -> exactly one further accept.
5. CREDIT_W=2, init=3 -> tx_credit_in gives cnt stays 3 and debug[30]=1. tx_credit_in together with a consume at cnt=1 -> cnt stays 1.
6. Assert rst_wr mid-traffic, both directions active -> every output 0 next edge, stickies cleared.

Source files
------------

// File: rtl/lpif_ll_pkg.sv
// Shared constants for the LPIF logic-link buffer: debug-status layout, size limits, width helpers.
// Pure declarations; no latency or flow-control behaviour of its own.
package lpif_ll_pkg;

   localparam int DBG_RX_OVF_BIT    = 31;
   localparam int DBG_TX_OVF_BIT    = 30;
   localparam int DBG_RX_ONLINE_BIT = 29;
   localparam int DBG_TX_ONLINE_BIT = 28;
   localparam int DBG_RX_CNT_LSB    = 8;
   localparam int DBG_CREDIT_LSB    = 0;

   localparam int MIN_DEPTH    = 2;
   localparam int MAX_DEPTH    = 128;
   localparam int MAX_CREDIT_W = 8;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic bit depth_ok(input int depth);
      return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/lpif_ll_sync_fifo.sv
// First-word-fall-through FIFO with flush; a write is visible on rd_data_o right after its edge.
// A write while full is only taken when a read frees the slot in the same cycle; flush beats everything.
module lpif_ll_sync_fifo
   import lpif_ll_pkg::*;
#(
   parameter  int DATA_W = 537,
   parameter  int DEPTH  = 16,
   localparam int PW     = ptr_w(DEPTH),
   localparam int CW     = PW + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              wr_en_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              empty_o,
   output logic              full_o,
   output logic [CW-1:0]     count_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              do_wr, do_rd;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == CW'(DEPTH));
   assign count_o   = count_q;
   assign rd_data_o = mem_q[rd_ptr_q];
   assign do_rd     = rd_en_i & ~empty_o;
   assign do_wr     = wr_en_i & (~full_o | do_rd);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
         if (do_wr && !do_rd) begin
            count_d = count_q + CW'(1);
         end else if (do_rd && !do_wr) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset: contents are only observable once count_q says so.
   always_ff @(posedge clk_i) begin
      if (do_wr && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/lpif_ll_credit_fifo.sv
// LPIF logic-link buffer: RX FIFO with per-pop credit return (1-cycle registered), TX credit gate with 1-cycle push.
// RX backpressure via rx_fifo_ready (overflow drops and flags); TX accepts only while credits remain.
module lpif_ll_credit_fifo
   import lpif_ll_pkg::*;
#(
   parameter int DATA_W   = 537,
   parameter int DEPTH    = 16,
   parameter int CREDIT_W = 8
) (
   input  logic              clk_wr,
   input  logic              rst_wr,
   input  logic              rx_online,
   input  logic              tx_online,
   input  logic [7:0]        init_upstream_credit,
   input  logic              rx_push,
   input  logic [DATA_W-1:0] rx_data,
   output logic              rx_fifo_valid,
   output logic [DATA_W-1:0] rx_fifo_data,
   input  logic              rx_fifo_ready,
   output logic              rx_credit_ret,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   input  logic              tx_credit_in,
   output logic              tx_push,
   output logic [DATA_W-1:0] tx_push_data,
   output logic [31:0]       rx_debug_status,
   output logic [31:0]       tx_debug_status
);

   localparam int CW = ptr_w(DEPTH) + 1;

   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("lpif_ll_credit_fifo: DEPTH must be a power of 2 in 2..128");
   end
   if (CREDIT_W < 1 || CREDIT_W > MAX_CREDIT_W) begin : g_bad_credit_w
      $error("lpif_ll_credit_fifo: CREDIT_W must be in 1..8");
   end

   logic              fifo_empty, fifo_full;
   logic [CW-1:0]     fifo_count;
   logic              rx_wr, rx_pop;
   logic              rx_ovf_q, rx_ovf_d;
   logic              cred_ret_q, cred_ret_d;

   logic              tx_online_q;
   logic              tx_rise, consume, cred_in;
   logic [CREDIT_W-1:0] cnt_q, cnt_d;
   logic              tx_ovf_q, tx_ovf_d;
   logic              tx_push_q;
   logic [DATA_W-1:0] tx_push_data_q, tx_push_data_d;
   logic [7:0]        rx_cnt8, cnt8;
   logic [31:0]       status;

   assign rx_wr         = rx_push & rx_online;
   assign rx_fifo_valid = ~fifo_empty;
   assign rx_pop        = rx_fifo_valid & rx_fifo_ready;

   lpif_ll_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_rx_fifo (
      .clk_i     (clk_wr),
      .rst_i     (rst_wr),
      .flush_i   (~rx_online),
      .wr_en_i   (rx_wr),
      .wr_data_i (rx_data),
      .rd_en_i   (rx_pop),
      .rd_data_o (rx_fifo_data),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full),
      .count_o   (fifo_count)
   );

   assign rx_ovf_d      = rx_ovf_q | (rx_wr & fifo_full & ~rx_pop);
   assign cred_ret_d    = rx_pop & rx_online;
   assign rx_credit_ret = cred_ret_q;

   // The rise cycle is spent loading the initial credit, so nothing is accepted then.
   assign tx_rise  = tx_online & ~tx_online_q;
   assign tx_ready = tx_online & ~tx_rise & (cnt_q != '0);
   assign consume  = tx_valid & tx_ready;
   assign cred_in  = tx_credit_in & tx_online;

   always_comb begin
      cnt_d          = cnt_q;
      tx_ovf_d       = tx_ovf_q;
      tx_push_data_d = consume ? tx_data : tx_push_data_q;
      if (!tx_online) begin
         cnt_d = '0;
      end else if (tx_rise) begin
         cnt_d = CREDIT_W'(init_upstream_credit);
      end else if (cred_in && !consume) begin
         if (&cnt_q) tx_ovf_d = 1'b1;
         else        cnt_d    = cnt_q + CREDIT_W'(1);
      end else if (consume && !cred_in) begin
         cnt_d = cnt_q - CREDIT_W'(1);
      end
   end

   always_ff @(posedge clk_wr) begin
      if (rst_wr) begin
         rx_ovf_q       <= 1'b0;
         cred_ret_q     <= 1'b0;
         tx_online_q    <= 1'b0;
         cnt_q          <= '0;
         tx_ovf_q       <= 1'b0;
         tx_push_q      <= 1'b0;
         tx_push_data_q <= '0;
      end else begin
         rx_ovf_q       <= rx_ovf_d;
         cred_ret_q     <= cred_ret_d;
         tx_online_q    <= tx_online;
         cnt_q          <= cnt_d;
         tx_ovf_q       <= tx_ovf_d;
         tx_push_q      <= consume;
         tx_push_data_q <= tx_push_data_d;
      end
   end

   assign tx_push      = tx_push_q;
   assign tx_push_data = tx_push_data_q;

   always_comb begin
      rx_cnt8 = '0;
      rx_cnt8[CW-1:0] = fifo_count;
      cnt8 = '0;
      cnt8[CREDIT_W-1:0] = cnt_q;
      status = '0;
      status[DBG_RX_OVF_BIT]           = rx_ovf_q;
      status[DBG_TX_OVF_BIT]           = tx_ovf_q;
      status[DBG_RX_ONLINE_BIT]        = rx_online;
      status[DBG_TX_ONLINE_BIT]        = tx_online;
      status[DBG_RX_CNT_LSB +: 8]      = rx_cnt8;
      status[DBG_CREDIT_LSB +: 8]      = cnt8;
   end

   assign rx_debug_status = status;
   assign tx_debug_status = status;

endmodule
